button_event_queue: RTL and testbench

Collects the single-cycle `clean` pulses produced by the per-button debouncers and turns them into an ordered stream of button-ID events for the game/control logic. Each button has a one-deep pending flag. Pending flags are serialised by fixed priority into a small FIFO. Events are presented on a valid/ready interface so the consumer can take them at its own rate without losing presses. Sits directly downstream of the debouncer bank, in the same 48.8 kHz clock domain.

---
 rtl/button_event_queue_if.sv | 25 ++
 rtl/button_event_queue.sv | 112 +++++++++++
 tb/tb_button_event_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/button_event_queue_if.sv
// Valid/ready event stream from button_event_queue to its consumer.
// The queue drives head ID and occupancy; the consumer drives ready.
interface button_event_queue_if #(
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 4
);
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_count;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_count,
    output evt_ready
  );
endinterface

// File: rtl/button_event_queue.sv
// Serialises debounced button pulses into an ordered FIFO of button IDs (valid/ready out).
// Optional BTN_EVT_DROP_CNT_EN adds an 8-bit saturating drop_count output.
module button_event_queue #(
  parameter int unsigned NUM_BTN = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BTN-1:0]   btn_pulse,
  button_event_queue_if.master evt,
  output logic                 overflow
`ifdef BTN_EVT_DROP_CNT_EN
  ,
  output logic [7:0]           drop_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] low_mask, push_mask, drop;
  logic [ID_W-1:0]    push_id;
  logic [ID_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q;
  logic               push, pop, not_empty;

  // Fixed priority: lowest set pending bit wins.
  always_comb begin
    push_id  = '0;
    low_mask = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_id  = ID_W'(i);
        low_mask = NUM_BTN'(1) << i;
      end
    end
  end

  // Push is gated on the pre-pop count, so a full queue never pushes through.
  always_comb begin
    not_empty = (count_q != '0);
    push      = (count_q < CNT_W'(DEPTH)) && (|pending_q);
    pop       = not_empty && evt.evt_ready;
    push_mask = push ? low_mask : '0;
    pending_d = (pending_q & ~push_mask) | btn_pulse;
    drop      = btn_pulse & pending_q & ~push_mask;
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      count_q    <= count_d;
      overflow_q <= |drop;
      if (push) begin
        mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_comb begin
    evt.evt_valid = not_empty;
    evt.evt_id    = not_empty ? mem_q[rd_ptr_q] : '0;
    evt.evt_count = count_q;
    overflow      = overflow_q;
  end

`ifdef BTN_EVT_DROP_CNT_EN
  logic [7:0] drop_count_q;
  logic [8:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_count_q};
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      drop_sum = drop_sum + 9'(drop[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_sum[8] ? 8'hff : drop_sum[7:0];
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench for button_event_queue: table vectors, corner sequences and a
// cycle model whose expected IDs form a scoreboard popped on each DUT handshake.
module tb_button_event_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_pulse;
  logic       overflow;
`ifdef BTN_EVT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  button_event_queue_if #(.ID_W(2), .CNT_W(4)) evt ();

  button_event_queue #(
    .NUM_BTN(4),
    .ID_W   (2),
    .DEPTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pulse (btn_pulse),
    .evt       (evt),
    .overflow  (overflow)
`ifdef BTN_EVT_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [3:0] m_pend;
  int       sb[$];
  bit       m_ovf;
  int       m_drop;

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    int         cnt;
    logic       vld;
    int         id;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    sb.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Drive one cycle of inputs, advance the model, clock the DUT, compare outputs.
  task automatic tick(input logic [3:0] b, input logic r);
    int       idx;
    bit       push_ok, pop;
    bit [3:0] pmask, drops;
    btn_pulse     = b;
    evt.evt_ready = r;
    idx = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i]) idx = i;
    push_ok = (sb.size() < 8) && (idx >= 0);
    pop     = r && (sb.size() > 0);
    pmask   = push_ok ? 4'(1 << idx) : 4'b0;
    if (evt.evt_valid && r && sb.size() > 0) chk("pop_id", 32'(evt.evt_id), 32'(sb[0]));
    drops  = b & m_pend & ~pmask;
    m_pend = (m_pend & ~pmask) | b;
    if (pop) void'(sb.pop_front());
    if (push_ok) sb.push_back(idx);
    m_ovf  = (drops != 0);
    m_drop = m_drop + $countones(drops);
    if (m_drop > 255) m_drop = 255;
    @(posedge clk);
    #1;
    chk("count", 32'(evt.evt_count), 32'(sb.size()));
    chk("valid", 32'(evt.evt_valid), 32'(sb.size() > 0));
    chk("id", 32'(evt.evt_id), (sb.size() > 0) ? 32'(sb[0]) : 32'd0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef BTN_EVT_DROP_CNT_EN
    chk("drop_count", 32'(drop_count), 32'(m_drop));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Single pulse on button 2 with ready high, then 4'b1011 with ready low and a drain.
    vecs[0]  = '{4'b0100, 1'b1, 0, 1'b0, 0, 1'b0};
    vecs[1]  = '{4'b0000, 1'b1, 1, 1'b1, 2, 1'b0};
    vecs[2]  = '{4'b0000, 1'b1, 0, 1'b0, 0, 1'b0};
    vecs[3]  = '{4'b1011, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[4]  = '{4'b0000, 1'b0, 1, 1'b1, 0, 1'b0};
    vecs[5]  = '{4'b0000, 1'b0, 2, 1'b1, 0, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 3, 1'b1, 0, 1'b0};
    vecs[7]  = '{4'b0000, 1'b1, 2, 1'b1, 1, 1'b0};
    vecs[8]  = '{4'b0000, 1'b1, 1, 1'b1, 3, 1'b0};
    vecs[9]  = '{4'b0000, 1'b1, 0, 1'b0, 0, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 0, 1'b0, 0, 1'b0};

    reset         = 1'b0;
    btn_pulse     = '0;
    evt.evt_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(evt.evt_valid), 32'd0);
    chk("rst_id", 32'(evt.evt_id), 32'd0);
    chk("rst_count", 32'(evt.evt_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    #4 reset = 1'b1;

    foreach (vecs[i]) begin
      tick(vecs[i].btn, vecs[i].rdy);
      chk($sformatf("vec%0d_count", i), 32'(evt.evt_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_valid", i), 32'(evt.evt_valid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_id", i), 32'(evt.evt_id), 32'(vecs[i].id));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    end

    // Fill: nine pulses rotating over buttons 0..3, ready low.
    for (int i = 0; i < 9; i++) tick(4'(1 << (i % 4)), 1'b0);
    tick(4'b0000, 1'b0);
    chk("full_count", 32'(evt.evt_count), 32'd8);
    tick(4'b0001, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
`ifdef BTN_EVT_DROP_CNT_EN
    chk("drop_one", 32'(drop_count), 32'd1);
`endif
    tick(4'b0000, 1'b0);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Full with button 0 pending: push is gated on the pre-pop count, so one slot frees.
    tick(4'b0010, 1'b1);
    chk("full_pop_no_pushthru", 32'(evt.evt_count), 32'd7);
    for (int i = 1; i < 20; i++) tick(4'(1 << ((i + 1) % 4)), 1'b1);
    chk("sustained_count", 32'(evt.evt_count), 32'd7);
    for (int n = 0; n < 40 && evt.evt_count != 0; n++) tick(4'b0000, 1'b1);
    chk("drain", 32'(evt.evt_count), 32'd0);

    // Pulse on button 1 in the same cycle its pending flag is pushed: set wins.
    tick(4'b0010, 1'b0);
    tick(4'b0010, 1'b0);
    chk("setwin_count1", 32'(evt.evt_count), 32'd1);
    tick(4'b0000, 1'b0);
    chk("setwin_count2", 32'(evt.evt_count), 32'd2);
    chk("setwin_id", 32'(evt.evt_id), 32'd1);
    chk("setwin_ovf", 32'(overflow), 32'd0);
    for (int n = 0; n < 40 && evt.evt_count != 0; n++) tick(4'b0000, 1'b1);

    // Build 5 queued + 2 pending, then reset asynchronously mid-cycle.
    tick(4'b1111, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0011, 1'b0);
    chk("pre_reset_count", 32'(evt.evt_count), 32'd5);
    btn_pulse = '0;
    #3 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(evt.evt_valid), 32'd0);
    chk("async_rst_id", 32'(evt.evt_id), 32'd0);
    chk("async_rst_count", 32'(evt.evt_count), 32'd0);
    chk("async_rst_ovf", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clk);
    #4 reset = 1'b1;
    for (int i = 0; i < 5; i++) tick(4'b0000, 1'b1);
    chk("post_reset_idle", 32'(evt.evt_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
